dsp_mac_pipe: RTL and testbench
===============================

// Module: dsp_mac_pipe
// PURPOSE
// Parametrised 4-stage pre-add / multiply / post-add DSP slice: P = A*(D +/- B) +/- Z.
// Runtime opmode selects add/sub per adder and post-add operand Z (C, P accumulate, or 0).
// Adds valid tracking, clock enable, signed mode and optional saturation.
// Feeds the filter/MAC datapaths; one instance per tap or channel.
// PARAMETERS
// A_W     18  width of A
// BD_W    18  width of B and D
// C_W     48  width of C (C_W <= P_W)
// P_W     48  width of P
// SIGNED  0   1: all operands two's complement, sign-extended; 0: unsigned, zero-extended
// SAT     0   1: saturate P on post-add overflow; 0: wrap modulo 2^P_W
// PORTS
// clk        in   1     clock, rising edge
// rst_n      in   1     asynchronous, active-low reset
// ce         in   1     clock enable; 0 freezes every stage
// in_valid   in   1     A,B,C,D,opmode valid this cycle
// opmode     in   4     [0] pre-sub, [1] post-sub, [3:2] Z sel: 00 C, 01 P, 10/11 zero
// A          in   A_W   multiplier operand
// B          in   BD_W  pre-adder operand (subtrahend when pre-sub)
// D          in   BD_W  pre-adder operand
// C          in   C_W   post-adder operand
// out_valid  out  1     P holds a new result
// P          out  P_W   result register
// ovf        out  1     post-add overflow/underflow for the beat now in P
// BEHAVIOUR
// - rst_n=0 (async, any cycle): all pipeline regs, out_valid, P, ovf -> 0; in-flight beats dropped.
// - Every register updates only when ce=1. ce=0: all data, valid, P, ovf hold.
// - S1: register A,B,C,D,opmode,in_valid.
// - S2: PRE = D +/- B, width BD_W+1 (carry/borrow kept); A and C,opmode delayed one stage.
// - S3: M = A * PRE, full width A_W+BD_W+1, then sign/zero-extend or truncate LSBs to P_W.
//   C and opmode delayed again so C aligns with its own product (C latency = A/B/D latency).
// - S4: Z per opmode[3:2]; SUM = M +/- Z computed in P_W+1 bits.
//   Unsigned: ovf = carry out (add) or borrow (sub). Signed: ovf = result sign mismatch.
//   SAT=1 and ovf: P = max (all ones / signed max) on overflow, min (0 / signed min) on underflow.
//   SAT=0: P = SUM mod 2^P_W, ovf still reported.
// - P, ovf and out_valid load only when S4 valid=1 and ce=1; invalid beats leave P untouched
//   (out_valid drops to 0), so bubbles never disturb an accumulation.
// - Latency: 4 enabled cycles from in_valid to out_valid; throughput 1 beat/enabled cycle.
// - Accumulate (Z=P) uses P as registered at that edge; back-to-back acc beats chain correctly
//   (P(n) = M(n) +/- P(n-1)). Z=zero starts a fresh accumulation.
// - opmode travels with its beat; changing opmode between beats never affects earlier beats.
// STRUCTURE
// - Shared include dsp_pkg: opmode bit indices and Z-select encodings (ZSEL_C, ZSEL_P, ZSEL_0).
// - One sub-module dsp_pipe_reg #(W): async active-low reset, ce-gated D flip-flop; used for
//   all stage registers. Arithmetic stays in the top module.
// TESTING
// - ADD: A=2,B=3,D=5,C=10, opmode=0000 -> 4 cycles later out_valid=1, P=26, ovf=0.
// - SUB unsigned, SAT=0: A=2,B=3,D=5,C=10, opmode=0011 -> P=0xFFFF_FFFF_FFFA, ovf=1;
//   same with SAT=1 -> P=0, ovf=1; SIGNED=1,SAT=0 -> P=-6, ovf=0.
// - Accumulate: beat0 A=1,D=1,B=0 Z=zero, then 3 beats Z=P back-to-back -> P=1,2,3,4 on
//   consecutive cycles; insert a bubble mid-run -> P holds, sequence resumes to 4.
// - Saturation: SAT=1, C=2^48-1, A=1,D=1,B=0, Z=C -> P=0xFFFF_FFFF_FFFF, ovf=1.
// - ce stall: 3 beats in flight, ce=0 for 5 cycles -> outputs frozen; ce=1 -> remaining
//   results emerge in order with no loss or duplication.
// - Reset mid-operation: rst_n low between clock edges with 2 beats in flight -> P, ovf,
//   out_valid 0 immediately; no stale beat emerges after release.

Source files
------------

// File: rtl/dsp_pkg.sv
// dsp_pkg: opmode field positions and post-adder Z-select encodings for dsp_mac_pipe
package dsp_pkg;
   localparam int OP_PRE_SUB  = 0;
   localparam int OP_POST_SUB = 1;
   localparam int OP_ZSEL_LO  = 2;
   localparam int OP_ZSEL_HI  = 3;
   typedef enum logic [1:0] {
      ZSEL_C = 2'b00,
      ZSEL_P = 2'b01,
      ZSEL_0 = 2'b10
   } zsel_t;
endpackage

// File: rtl/dsp_pipe_reg.sv
// dsp_pipe_reg: clock-enabled pipeline register with asynchronous active-low clear
module dsp_pipe_reg #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ce,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   // load on enabled edges, clear immediately on reset
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (ce) q <= d;
endmodule

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: 4-stage pre-add / multiply / post-add slice, P = A*(D +/- B) +/- Z
module dsp_mac_pipe import dsp_pkg::*; #(
   parameter int A_W    = 18,
   parameter int BD_W   = 18,
   parameter int C_W    = 48,
   parameter int P_W    = 48,
   parameter int SIGNED = 0,
   parameter int SAT    = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ce,
   input  logic            in_valid,
   input  logic [3:0]      opmode,
   input  logic [A_W-1:0]  A,
   input  logic [BD_W-1:0] B,
   input  logic [BD_W-1:0] D,
   input  logic [C_W-1:0]  C,
   output logic            out_valid,
   output logic [P_W-1:0]  P,
   output logic            ovf
);
   localparam int MW = A_W + BD_W + 1;
   localparam bit SX = SIGNED != 0;
   logic [A_W-1:0]  a1, a2;
   logic [BD_W-1:0] b1, d1;
   logic [C_W-1:0]  c1, c2, c3;
   logic [3:0]      op1;
   logic [3:1]      op2, op3;
   logic            v1, v2, v3;
   logic [BD_W:0]   b_x, d_x, pre, pre2;
   logic [MW-1:0]   a_x, pre_x, m_full;
   logic [P_W-1:0]  m_ext, m3, c_x, z, sat_val, p_next;
   logic [P_W:0]    m_w, z_w, sum;
   logic            ovf_next;
   zsel_t           zsel;

   // stage 1: capture operands, opmode and valid
   dsp_pipe_reg #(A_W)  u_a1  (.clk(clk), .rst_n(rst_n), .ce(ce), .d(A),        .q(a1));
   dsp_pipe_reg #(BD_W) u_b1  (.clk(clk), .rst_n(rst_n), .ce(ce), .d(B),        .q(b1));
   dsp_pipe_reg #(BD_W) u_d1  (.clk(clk), .rst_n(rst_n), .ce(ce), .d(D),        .q(d1));
   dsp_pipe_reg #(C_W)  u_c1  (.clk(clk), .rst_n(rst_n), .ce(ce), .d(C),        .q(c1));
   dsp_pipe_reg #(4)    u_op1 (.clk(clk), .rst_n(rst_n), .ce(ce), .d(opmode),   .q(op1));
   dsp_pipe_reg #(1)    u_v1  (.clk(clk), .rst_n(rst_n), .ce(ce), .d(in_valid), .q(v1));

   // pre-adder keeps the carry/borrow bit so the multiplier sees the exact D +/- B
   always_comb begin
      b_x = {SX & b1[BD_W-1], b1};
      d_x = {SX & d1[BD_W-1], d1};
      pre = op1[OP_PRE_SUB] ? d_x - b_x : d_x + b_x;
   end

   // stage 2: pre-add result; A, C and the remaining opmode bits ride along
   dsp_pipe_reg #(BD_W+1) u_pre2 (.clk(clk), .rst_n(rst_n), .ce(ce), .d(pre),      .q(pre2));
   dsp_pipe_reg #(A_W)    u_a2   (.clk(clk), .rst_n(rst_n), .ce(ce), .d(a1),       .q(a2));
   dsp_pipe_reg #(C_W)    u_c2   (.clk(clk), .rst_n(rst_n), .ce(ce), .d(c1),       .q(c2));
   dsp_pipe_reg #(3)      u_op2  (.clk(clk), .rst_n(rst_n), .ce(ce), .d(op1[3:1]), .q(op2));
   dsp_pipe_reg #(1)      u_v2   (.clk(clk), .rst_n(rst_n), .ce(ce), .d(v1),       .q(v2));

   // full-width product; operands extended to MW so the low MW bits are exact in either mode
   always_comb begin
      a_x    = {{(MW-A_W){SX & a2[A_W-1]}}, a2};
      pre_x  = {{(MW-BD_W-1){SX & pre2[BD_W]}}, pre2};
      m_full = a_x * pre_x;
   end

   if (P_W > MW) begin : g_m_ext
      assign m_ext = {{(P_W-MW){SX & m_full[MW-1]}}, m_full};
   end else begin : g_m_trunc
      assign m_ext = m_full[P_W-1:0];
   end

   // stage 3: product; C delayed again so it meets its own product at the post-adder
   dsp_pipe_reg #(P_W) u_m3  (.clk(clk), .rst_n(rst_n), .ce(ce), .d(m_ext), .q(m3));
   dsp_pipe_reg #(C_W) u_c3  (.clk(clk), .rst_n(rst_n), .ce(ce), .d(c2),    .q(c3));
   dsp_pipe_reg #(3)   u_op3 (.clk(clk), .rst_n(rst_n), .ce(ce), .d(op2),   .q(op3));
   dsp_pipe_reg #(1)   u_v3  (.clk(clk), .rst_n(rst_n), .ce(ce), .d(v2),    .q(v3));

   if (P_W > C_W) begin : g_c_ext
      assign c_x = {{(P_W-C_W){SX & c3[C_W-1]}}, c3};
   end else begin : g_c_same
      assign c_x = c3;
   end

   // post-adder in P_W+1 bits; the extra bit gives carry/borrow or the true sign for saturation
   always_comb begin
      zsel     = zsel_t'(op3[OP_ZSEL_HI:OP_ZSEL_LO]);
      z        = zsel == ZSEL_C ? c_x : zsel == ZSEL_P ? P : '0;
      m_w      = {SX & m3[P_W-1], m3};
      z_w      = {SX & z[P_W-1], z};
      sum      = op3[OP_POST_SUB] ? m_w - z_w : m_w + z_w;
      ovf_next = SX ? sum[P_W] ^ sum[P_W-1] : sum[P_W];
      sat_val  = SX ? {sum[P_W], {(P_W-1){~sum[P_W]}}} : {P_W{~op3[OP_POST_SUB]}};
      p_next   = (SAT != 0 && ovf_next) ? sat_val : sum[P_W-1:0];
   end

   // stage 4: P and ovf load only for valid beats so bubbles leave an accumulation intact
   dsp_pipe_reg #(P_W+1) u_p  (.clk(clk), .rst_n(rst_n), .ce(ce & v3), .d({ovf_next, p_next}), .q({ovf, P}));
   dsp_pipe_reg #(1)     u_ov (.clk(clk), .rst_n(rst_n), .ce(ce),      .d(v3),                 .q(out_valid));
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb_dsp_mac_pipe: directed and random checks of four dsp_mac_pipe variants against a behavioural model
module tb_dsp_mac_pipe;
   typedef struct {
      bit          v;
      logic [3:0]  op;
      logic [17:0] a, b, d;
      logic [47:0] c;
   } beat_t;

   logic        clk = 0, rst_n = 0, ce = 1, in_valid = 0;
   logic [3:0]  opmode = '0;
   logic [17:0] a = '0, b = '0, d = '0;
   logic [47:0] c = '0;
   logic [3:0]  ov, ovf;
   logic [47:0] p [4];
   int          nvec = 0, nerr = 0;
   beat_t       pipe [$];
   logic [47:0] exp_p [4];
   bit          exp_ovf [4];
   bit          exp_ov;

   always #5 clk = ~clk;

   // instance g: SIGNED = g/2, SAT = g%2
   for (genvar g = 0; g < 4; g++) begin : g_dut
      dsp_mac_pipe #(.A_W(18), .BD_W(18), .C_W(48), .P_W(48), .SIGNED(g / 2), .SAT(g % 2)) u (
         .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .opmode(opmode),
         .A(a), .B(b), .D(d), .C(c), .out_valid(ov[g]), .P(p[g]), .ovf(ovf[g]));
   end

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // arithmetic meaning of one beat for variant g, applied to that variant's expected P
   function automatic void ref_beat(int g, beat_t bt);
      bit     sg = (g / 2) != 0, st = (g % 2) != 0;
      longint av, bv, dv, pre, m, z, s, hi, lo;
      av = sg ? longint'($signed(bt.a)) : longint'(bt.a);
      bv = sg ? longint'($signed(bt.b)) : longint'(bt.b);
      dv = sg ? longint'($signed(bt.d)) : longint'(bt.d);
      pre = bt.op[0] ? dv - bv : dv + bv;
      if (!sg && pre < 0) pre += 64'sd1 <<< 19;
      m = av * pre;
      case (bt.op[3:2])
         2'b00:   z = sg ? longint'($signed(bt.c)) : longint'(bt.c);
         2'b01:   z = sg ? longint'($signed(exp_p[g])) : longint'(exp_p[g]);
         default: z = 0;
      endcase
      s  = bt.op[1] ? m - z : m + z;
      hi = sg ? (64'sd1 <<< 47) - 1 : (64'sd1 <<< 48) - 1;
      lo = sg ? -(64'sd1 <<< 47) : 0;
      exp_ovf[g] = s > hi || s < lo;
      if (st && exp_ovf[g]) s = s > hi ? hi : lo;
      exp_p[g] = s[47:0];
   endfunction

   function automatic void clear_model();
      pipe.delete();
      exp_ov = 0;
      for (int g = 0; g < 4; g++) begin
         exp_p[g] = '0;
         exp_ovf[g] = 0;
      end
   endfunction

   task automatic check_all(string tag);
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("%s.out_valid%0d", tag, g), ov[g], exp_ov);
         chk($sformatf("%s.P%0d", tag, g), p[g], exp_p[g]);
         chk($sformatf("%s.ovf%0d", tag, g), ovf[g], exp_ovf[g]);
      end
   endtask

   // one clock: drive inputs, advance the model on enabled edges, compare all variants
   task automatic tick(bit v, logic [3:0] op, logic [17:0] aa, logic [17:0] bb, logic [17:0] dd,
                       logic [47:0] cc, bit e = 1);
      beat_t bt;
      in_valid = v; opmode = op; a = aa; b = bb; d = dd; c = cc; ce = e;
      @(posedge clk);
      #1;
      if (e) begin
         bt = '{v: v, op: op, a: aa, b: bb, d: dd, c: cc};
         pipe.push_back(bt);
         if (pipe.size() > 3) begin
            bt = pipe.pop_front();
            exp_ov = bt.v;
            if (bt.v) for (int g = 0; g < 4; g++) ref_beat(g, bt);
         end
      end
      check_all("tick");
   endtask

   task automatic bubbles(int n);
      for (int i = 0; i < n; i++) tick(0, 4'd0, '0, '0, '0, '0);
   endtask

   initial begin
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1;

      tick(1, 4'b0000, 18'd2, 18'd3, 18'd5, 48'd10);
      bubbles(3);
      chk("add.P", p[0], 48'd26);
      chk("add.ovf", ovf[0], 1'b0);
      chk("add.out_valid", ov[0], 1'b1);
      bubbles(1);
      chk("add.hold", p[0], 48'd26);
      chk("add.valid_drop", ov[0], 1'b0);

      tick(1, 4'b0011, 18'd2, 18'd3, 18'd5, 48'd10);
      bubbles(3);
      chk("sub.P_wrap", p[0], 48'hFFFF_FFFF_FFFA);
      chk("sub.ovf_wrap", ovf[0], 1'b1);
      chk("sub.P_sat", p[1], 48'd0);
      chk("sub.ovf_sat", ovf[1], 1'b1);
      chk("sub.P_signed", p[2], 48'hFFFF_FFFF_FFFA);
      chk("sub.ovf_signed", ovf[2], 1'b0);

      tick(1, 4'b1000, 18'd1, 18'd0, 18'd1, '0);
      repeat (3) tick(1, 4'b0100, 18'd1, 18'd0, 18'd1, '0);
      chk("acc.1", p[0], 48'd1);
      bubbles(1);
      chk("acc.2", p[0], 48'd2);
      bubbles(1);
      chk("acc.3", p[0], 48'd3);
      bubbles(1);
      chk("acc.4", p[0], 48'd4);

      tick(1, 4'b1000, 18'd1, 18'd0, 18'd1, '0);
      tick(1, 4'b0100, 18'd1, 18'd0, 18'd1, '0);
      tick(0, 4'b0100, 18'd1, 18'd0, 18'd1, '0);
      tick(1, 4'b0100, 18'd1, 18'd0, 18'd1, '0);
      chk("accb.1", p[0], 48'd1);
      tick(1, 4'b0100, 18'd1, 18'd0, 18'd1, '0);
      chk("accb.2", p[0], 48'd2);
      bubbles(1);
      chk("accb.hold", p[0], 48'd2);
      chk("accb.hold_valid", ov[0], 1'b0);
      bubbles(1);
      chk("accb.3", p[0], 48'd3);
      bubbles(1);
      chk("accb.4", p[0], 48'd4);

      tick(1, 4'b0000, 18'd1, 18'd0, 18'd1, 48'hFFFF_FFFF_FFFF);
      bubbles(3);
      chk("sat.P", p[1], 48'hFFFF_FFFF_FFFF);
      chk("sat.ovf", ovf[1], 1'b1);
      chk("sat.P_wrap", p[0], 48'd0);

      for (int i = 0; i < 3; i++)
         tick(1, 4'($urandom_range(0, 11)), 18'($urandom), 18'($urandom), 18'($urandom),
              48'({$urandom, $urandom}));
      for (int i = 0; i < 5; i++)
         tick(1, 4'($urandom), 18'($urandom), 18'($urandom), 18'($urandom),
              48'({$urandom, $urandom}), 0);
      bubbles(4);

      tick(1, 4'b0000, 18'd7, 18'd1, 18'd2, 48'd5);
      tick(1, 4'b0000, 18'd9, 18'd2, 18'd3, 48'd6);
      #2;
      rst_n = 0;
      #1;
      clear_model();
      check_all("async_rst");
      @(negedge clk);
      rst_n = 1;
      bubbles(5);

      for (int i = 0; i < 400; i++) begin
         logic [47:0] cc;
         cc = 48'({$urandom, $urandom});
         if ($urandom_range(0, 3) == 0) cc = $urandom_range(0, 1) != 0 ? 48'hFFFF_FFFF_FFFF : 48'h8000_0000_0000;
         tick($urandom_range(0, 4) != 0, 4'($urandom), 18'($urandom), 18'($urandom), 18'($urandom),
              cc, $urandom_range(0, 9) != 0);
      end
      bubbles(4);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
